// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared ISA constants, FSM state encoding and control bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_WB      = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic mem_to_reg;
    logic reg_dst;
  } ctrl_t;

  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module   : ctrl_decode
// Brief    : Moore control decode from (state, opcode) to datapath strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic [1:0] i_op,
  output ctrl_t      o_ctrl
);

  logic w_is_lw;
  logic w_is_sw;
  logic w_is_add;

  assign w_is_lw  = (i_op == OP_LW);
  assign w_is_sw  = (i_op == OP_SW);
  assign w_is_add = (i_op == OP_ADD);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_EXECUTE: begin
        o_ctrl.mem_write  = w_is_sw;
        o_ctrl.alu_src    = w_is_lw | w_is_sw;
        o_ctrl.mem_read   = w_is_lw;
        o_ctrl.mem_to_reg = w_is_lw;
        o_ctrl.reg_dst    = w_is_add;
      end
      S_WB: begin
        o_ctrl.reg_write  = w_is_add | w_is_lw;
        o_ctrl.alu_src    = w_is_lw;
        o_ctrl.mem_read   = w_is_lw;
        o_ctrl.mem_to_reg = w_is_lw;
        o_ctrl.reg_dst    = w_is_add;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_decode.sv
// ============================================================================
// Module   : instr_fetch_decode
// Brief    : Multi-cycle fetch/decode/control unit holding PC, IR and FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_decode
  import cpu_pkg::*;
(
  input  logic       Clk,
  input  logic       Clear,
  input  logic       Run,
  output logic [7:0] Imem_Addr,
  input  logic [7:0] Imem_Data,
  output logic [7:0] Instruction,
  output logic [3:0] Instruction52,
  output logic [1:0] Write_Register,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic [7:0] Sign_Ext,
  output logic [7:0] PC,
  output logic [1:0] State
);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [1:0] w_op;
  ctrl_t      w_ctrl;

  assign w_op = r_ir[7:6];

  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_state <= S_FETCH;
      r_pc    <= 8'h00;
      r_ir    <= 8'h00;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (Run) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir    <= Imem_Data;
          r_pc    <= r_pc + 8'd1;
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          // Jump offset applies to the PC already advanced in DECODE.
          if (w_op == OP_J) r_pc <= r_pc + {r_ir[5], r_ir[5], r_ir[5:0]};
          r_state <= ((w_op == OP_ADD) || (w_op == OP_LW)) ? S_WB : S_FETCH;
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_decode u_ctrl_decode (
    .i_state (r_state),
    .i_op    (w_op),
    .o_ctrl  (w_ctrl)
  );

  assign Imem_Addr      = r_pc;
  assign PC             = r_pc;
  assign State          = r_state;
  assign Instruction    = r_ir;
  assign Instruction52  = r_ir[5:2];
  assign Sign_Ext       = sext2(r_ir[1:0]);
  assign Write_Register = w_ctrl.reg_dst ? r_ir[1:0] : r_ir[3:2];
  assign RegWrite       = w_ctrl.reg_write;
  assign MemRead        = w_ctrl.mem_read;
  assign MemWrite       = w_ctrl.mem_write;
  assign ALUSrc         = w_ctrl.alu_src;
  assign MemtoReg       = w_ctrl.mem_to_reg;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
// ============================================================================
// Module   : tb_instr_fetch_decode
// Brief    : Self-checking bench with an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_decode;

  logic       Clk = 1'b0;
  logic       Clear;
  logic       Run;
  logic [7:0] Imem_Data;
  logic [7:0] Imem_Addr, Instruction, Sign_Ext, PC;
  logic [3:0] Instruction52;
  logic [1:0] Write_Register, State;
  logic       RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rom [256];
  int         m_pc;
  logic [7:0] m_ir;

  instr_fetch_decode dut (
    .Clk            (Clk),
    .Clear          (Clear),
    .Run            (Run),
    .Imem_Addr      (Imem_Addr),
    .Imem_Data      (Imem_Data),
    .Instruction    (Instruction),
    .Instruction52  (Instruction52),
    .Write_Register (Write_Register),
    .RegWrite       (RegWrite),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .ALUSrc         (ALUSrc),
    .MemtoReg       (MemtoReg),
    .Sign_Ext       (Sign_Ext),
    .PC             (PC),
    .State          (State)
  );

  always #5 Clk = ~Clk;

  function automatic logic [42:0] obs();
    return {State, PC, Imem_Addr, Instruction, Instruction52, Sign_Ext,
            RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg};
  endfunction

  // Expected outputs for cycle k of an instruction starting at pc.
  function automatic logic [42:0] expv(input int k, input int pc, input logic [7:0] ir_now);
    int         op;
    int         p;
    int         imm;
    bit         lw, sw;
    logic [4:0] c;
    op  = int'(ir_now[7:6]);
    lw  = (op == 1);
    sw  = (op == 2);
    p   = (k >= 2) ? (pc + 1) % 256 : pc;
    imm = int'(ir_now[1:0]);
    if (imm > 1) imm -= 4;
    c = 5'b0;
    if (k == 2) c = {1'b0, lw, sw, lw | sw, lw};
    if (k == 3) c = {1'b1, lw, 1'b0, lw, lw};
    return {2'(k), 8'(p), 8'(p), ir_now, ir_now[5:2], 8'(imm), c};
  endfunction

  task automatic do_clear();
    Clear     = 1'b1;
    Run       = 1'($urandom);
    Imem_Data = 8'($urandom);
    @(posedge Clk); #1;
    Clear = 1'b0;
    m_pc  = 0;
    m_ir  = 8'h00;
  endtask

  // Steps one instruction through the DUT, checking every cycle.
  task automatic run_instr(input bit rand_run, input int abort_at);
    logic [7:0]  ir_new;
    logic [42:0] e;
    logic [1:0]  exp_wr;
    int          op, ncyc, off;
    ir_new = rom[m_pc];
    op     = int'(ir_new[7:6]);
    ncyc   = (op <= 1) ? 4 : 3;
    for (int k = 0; k < ncyc; k++) begin
      e = expv(k, m_pc, (k >= 2) ? ir_new : m_ir);
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL cycle pc=%02h k=%0d: got %h want %h", m_pc[7:0], k, obs(), e);
      end
      if (k >= 2 && op <= 1) begin
        exp_wr = (op == 0) ? ir_new[1:0] : ir_new[3:2];
        n_vec++;
        if (Write_Register !== exp_wr) begin
          n_err++;
          $display("FAIL wreg pc=%02h k=%0d: got %0d want %0d", m_pc[7:0], k, Write_Register, exp_wr);
        end
      end
      Clear     = (k == abort_at);
      Run       = (k == 0) ? 1'b1 : (rand_run ? 1'($urandom) : 1'b0);
      Imem_Data = (k == 1) ? rom[m_pc] : 8'($urandom);
      @(posedge Clk); #1;
      if (k == abort_at) begin
        Clear = 1'b0;
        m_pc  = 0;
        m_ir  = 8'h00;
        return;
      end
    end
    m_ir = ir_new;
    if (op == 3) begin
      off = int'(ir_new[5:0]);
      if (off > 31) off -= 64;
      m_pc = (m_pc + 1 + off + 256) % 256;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      do_clear();
      n_vec++;
      if (obs() !== 43'h0) begin
        n_err++;
        $display("FAIL reset: got %h want 0", obs());
      end
    end
    for (int i = 0; i < 3; i++) begin
      Run = 1'b0;
      @(posedge Clk); #1;
      n_vec++;
      if (obs() !== 43'h0) begin
        n_err++;
        $display("FAIL reset_hold: got %h want 0", obs());
      end
    end
  endtask

  task automatic test_add_lw();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h1B;
    rom[1] = 8'h46;
    do_clear();
    run_instr(1'b1, -1);
    n_vec++;
    if (PC !== 8'h01) begin
      n_err++;
      $display("FAIL add_pc: got %02h want 01", PC);
    end
    run_instr(1'b1, -1);
  endtask

  task automatic test_sw_jump();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'hC3;
    rom[4] = 8'h86;
    rom[5] = 8'hFF;
    do_clear();
    run_instr(1'b1, -1);
    n_vec++;
    if (PC !== 8'h04) begin
      n_err++;
      $display("FAIL jump_fwd: got %02h want 04", PC);
    end
    run_instr(1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      run_instr(1'b1, -1);
      n_vec++;
      if (PC !== 8'h05 || State !== 2'd0) begin
        n_err++;
        $display("FAIL jump_loop: got pc=%02h st=%0d want pc=05 st=0", PC, State);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0]   = 8'hFE;
    rom[255] = 8'h1B;
    do_clear();
    run_instr(1'b1, -1);
    n_vec++;
    if (PC !== 8'hFF) begin
      n_err++;
      $display("FAIL wrap_jump: got %02h want ff", PC);
    end
    run_instr(1'b1, -1);
    n_vec++;
    if (PC !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_pc: got %02h want 00", PC);
    end
  endtask

  task automatic test_clear_wb();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h1B;
    do_clear();
    run_instr(1'b1, 3);
    n_vec++;
    if (obs() !== 43'h0) begin
      n_err++;
      $display("FAIL clear_wb: got %h want 0", obs());
    end
    for (int i = 0; i < 3; i++) begin
      Run = 1'b0;
      @(posedge Clk); #1;
      n_vec++;
      if (RegWrite !== 1'b0 || State !== 2'd0) begin
        n_err++;
        $display("FAIL clear_wb_hold: got rw=%b st=%0d want rw=0 st=0", RegWrite, State);
      end
    end
  endtask

  task automatic test_run_low();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h46;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      Run       = 1'b0;
      Imem_Data = 8'($urandom);
      @(posedge Clk); #1;
      n_vec++;
      if (State !== 2'd0 || PC !== 8'h00) begin
        n_err++;
        $display("FAIL run_low: got st=%0d pc=%02h want st=0 pc=00", State, PC);
      end
    end
    run_instr(1'b0, -1);
    for (int i = 0; i < 5; i++) begin
      Run = 1'b0;
      @(posedge Clk); #1;
      n_vec++;
      if (State !== 2'd0 || PC !== 8'h01) begin
        n_err++;
        $display("FAIL run_pulse_hold: got st=%0d pc=%02h want st=0 pc=01", State, PC);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_clear();
    for (int i = 0; i < 200; i++) run_instr(1'b1, -1);
  endtask

  initial begin
    Clear     = 1'b0;
    Run       = 1'b0;
    Imem_Data = 8'h00;
    m_pc      = 0;
    m_ir      = 8'h00;
    test_reset();
    test_add_lw();
    test_sw_jump();
    test_wrap();
    test_clear_wb();
    test_run_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Multi-cycle instruction fetch, decode and control unit for the 8-bit, four-register processor. It holds the PC and the instruction register (IR), and reads a synchronous instruction ROM. It sequences every instruction through a fixed state machine. It drives the register file's read selectors, write selector and write enable, plus the ALU and data-memory control lines. It sits directly upstream of the register file and feeds all of that block's control inputs.

## Interface
Parameters: none; widths are fixed by the ISA.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Clear  in  1  reset, synchronous, active-high
- Run  in  1  when low, the unit holds in FETCH after completing the current instruction
- Imem_Addr  out  8  instruction ROM address; always equals PC
- Imem_Data  in  8  ROM data; valid one cycle after Imem_Addr is presented
- Instruction  out  8  current IR
- Instruction52  out  4  IR[5:2]; register-file read selectors (rs = [3:2], rt = [1:0])
- Write_Register  out  2  destination: IR[1:0] for add, IR[3:2] for lw
- RegWrite  out  1  register-file write enable
- MemRead, MemWrite  out  1 each  data-memory strobes
- ALUSrc  out  1  1 selects Sign_Ext as the ALU B operand
- MemtoReg  out  1  1 selects memory data as the write-back source
- Sign_Ext  out  8  IR[1:0] sign-extended to 8 bits
- PC  out  8  program counter
- State  out  2  FSM state, for the seven-segment debug display

## Operation
- Instruction format: op = IR[7:6], rs = IR[5:4], rt = IR[3:2], rd/imm = IR[1:0].
- Opcodes:
  - 00 add: rd ← rs + rt
  - 01 lw: rt ← mem[rs + sext(imm)]
  - 10 sw: mem[rs + sext(imm)] ← rt
  - 11 j: PC ← PC + sext(IR[5:0])
- Jump offset is relative to the already-incremented PC.
- FSM states, encoding FETCH = 0, DECODE = 1, EXECUTE = 2, WRITEBACK = 3:
  - FETCH: Imem_Addr = PC. Go to DECODE if Run is high, otherwise stay.
  - DECODE: IR ← Imem_Data; PC ← PC + 1 (mod 256). Go to EXECUTE.
  - EXECUTE:
    - sw: MemWrite = 1, then go to FETCH.
    - j: PC ← PC + {IR[5], IR[5], IR[5:0]} (mod 256), then go to FETCH.
    - add/lw: go to WRITEBACK.
  - WRITEBACK: RegWrite = 1. Then go to FETCH.
- Control levels are Moore outputs, functions of state and IR only.
  - ALUSrc = 1 and MemRead = 1 for lw/sw in EXECUTE and WRITEBACK; MemRead applies to lw only.
  - MemtoReg = 1 for lw in EXECUTE and WRITEBACK.
  - Every control is 0 in FETCH and DECODE.
- RegWrite and MemWrite are never asserted in any state other than the one listed above.
- Arithmetic: all PC arithmetic is 8-bit and wraps silently; 0xFF + 1 = 0x00.

## Timing
- Instruction latency: add/lw take 4 cycles, sw/j take 3 cycles, counted from entering FETCH with Run high.
- Reset values, at the first edge with Clear high:
  - State = FETCH
  - PC = 0x00, IR = 0x00
  - All control outputs 0
  - Imem_Addr = 0x00
- Clear dominates every other input.
- Clear mid-instruction aborts it.
  - If Clear is sampled while in EXECUTE or WRITEBACK, no further write is issued.
  - The register file's own Clear covers the Clear cycle itself.
- Run is sampled only in FETCH. Dropping Run mid-instruction does not stall that instruction.
- Imem_Data is sampled only on the DECODE edge. Changes at any other time are ignored.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_ADD, OP_LW, OP_SW, OP_J
  - state encoding constants S_FETCH through S_WB
- These constants are also used by the display logic.
- One combinational sub-module, `ctrl_decode`, maps (state, op) to {RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg, RegDst}.
- The PC, IR and FSM registers remain in the top module.

## Test plan
- Clear, then Run = 1, ROM[0] = 0x1B (add r3, r1, r2):
  - Instruction52 = 4'b0110, Write_Register = 3
  - RegWrite high only in cycle 4
  - PC = 1 after DECODE
- ROM[1] = 0x46 (lw r1, -2(r0)):
  - Sign_Ext = 0xFE, ALUSrc = MemRead = MemtoReg = 1
  - Write_Register = 1, RegWrite in WRITEBACK only
- sw 0x86 followed by j 0xFF at address 5:
  - MemWrite pulses for exactly one cycle with no RegWrite
  - the jump yields PC = 5 repeatedly, 3 cycles per iteration
- PC preloaded to 0xFF via a jump chain, then an add is fetched: PC wraps to 0x00.
- Clear asserted while State = WRITEBACK: the next cycle shows State = 0, PC = 0, RegWrite = 0, and no second write occurs.
- Run low from reset: State remains 0 and PC remains 0 for 20 cycles. Run pulsed high for one cycle then runs exactly one instruction, which returns to FETCH and holds.
